mem_access_unit: RTL and testbench

//   M-stage load/store engine for the pipelined MIPS core; the write-side counterpart of immediate/data widening.

---
 rtl/mem_access_unit_pkg.sv | 44 ++++
 rtl/mem_access_unit_load_lane_ext.sv | 36 +++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared memory-op codes, exception codes and FSM state type for the M-stage
// load/store engine.
package mem_access_unit_pkg;

  localparam int unsigned MEMOP_SIZE = 4;

  // Code 0 and 9..15 are undefined ops: accepted, but nothing is sent to memory.
  localparam logic [MEMOP_SIZE-1:0] MEMOP_LW  = 4'd1;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_LH  = 4'd2;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_LHU = 4'd3;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_LB  = 4'd4;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_LBU = 4'd5;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_SW  = 4'd6;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_SH  = 4'd7;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_SB  = 4'd8;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    MAU_IDLE,
    MAU_ISSUE,
    MAU_WAIT,
    MAU_DONE
  } mau_state_e;

  function automatic logic is_load(input logic [MEMOP_SIZE-1:0] op);
    return op inside {MEMOP_LW, MEMOP_LH, MEMOP_LHU, MEMOP_LB, MEMOP_LBU};
  endfunction

  function automatic logic is_store(input logic [MEMOP_SIZE-1:0] op);
    return op inside {MEMOP_SW, MEMOP_SH, MEMOP_SB};
  endfunction

  function automatic logic is_misaligned(input logic [MEMOP_SIZE-1:0] op,
                                         input logic [1:0]            lo);
    logic w_bad;
    w_bad = 1'b0;
    if (op inside {MEMOP_LW, MEMOP_SW})              w_bad = (lo != 2'b00);
    if (op inside {MEMOP_LH, MEMOP_LHU, MEMOP_SH})   w_bad = lo[0];
    return w_bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_lane_ext.sv
// Load lane selection and sign/zero extension of the returned memory word.
module load_lane_ext
  import mem_access_unit_pkg::*;
(
  input  logic [MEMOP_SIZE-1:0] i_op,
  input  logic [1:0]            i_addr_lo,
  input  logic [31:0]           i_rdata,
  output logic [31:0]           o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_data = '0;
    case (i_op)
      MEMOP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MEMOP_LBU: o_data = {24'h000000, w_byte};
      MEMOP_LH:  o_data = {{16{w_half[15]}}, w_half};
      MEMOP_LHU: o_data = {16'h0000, w_half};
      MEMOP_LW:  o_data = i_rdata;
      default:   o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store engine: store narrowing, req/gnt/rvalid handshake, load extension.
// Optional MAU_MISALIGN_EXC_EN raises AdEL/AdES on misaligned accesses instead of issuing them.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned EXC_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [MEMOP_SIZE-1:0] req_op,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [EXC_W-1:0]      resp_exc,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [3:0]            mem_byteen,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rvalid
);

  mau_state_e            r_state;
  logic [MEMOP_SIZE-1:0] r_op;
  logic [1:0]            r_lane;
  logic [31:0]           w_st_wdata;
  logic [3:0]            w_st_byteen;
  logic [31:0]           w_ld_data;
  logic                  w_misaligned;

  assign req_ready = (r_state == MAU_IDLE);

  always_comb begin
    w_st_wdata  = req_wdata;
    w_st_byteen = 4'b0000;
    case (req_op)
      MEMOP_SB: begin
        w_st_wdata  = {4{req_wdata[7:0]}};
        w_st_byteen = 4'b0001 << req_addr[1:0];
      end
      MEMOP_SH: begin
        w_st_wdata  = {2{req_wdata[15:0]}};
        w_st_byteen = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      MEMOP_SW: w_st_byteen = 4'b1111;
      default: ;
    endcase
  end

`ifdef MAU_MISALIGN_EXC_EN
  assign w_misaligned = is_misaligned(req_op, req_addr[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  load_lane_ext u_load_lane_ext (
    .i_op      (r_op),
    .i_addr_lo (r_lane),
    .i_rdata   (mem_rdata),
    .o_data    (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= MAU_IDLE;
      r_op       <= '0;
      r_lane     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_byteen <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_exc   <= '0;
    end else begin
      case (r_state)
        MAU_IDLE: begin
          if (req_valid) begin
            r_op   <= req_op;
            r_lane <= req_addr[1:0];
            if (w_misaligned) begin
              r_state    <= MAU_DONE;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_exc   <= is_store(req_op) ? EXC_W'(EXC_ADES) : EXC_W'(EXC_ADEL);
            end else if (is_load(req_op) || is_store(req_op)) begin
              r_state    <= MAU_ISSUE;
              mem_req    <= 1'b1;
              mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_byteen <= w_st_byteen;
              mem_wdata  <= w_st_wdata;
            end else begin
              r_state    <= MAU_DONE;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_exc   <= '0;
            end
          end
        end
        MAU_ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (is_store(r_op)) begin
              r_state    <= MAU_DONE;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_exc   <= '0;
            end else begin
              r_state <= MAU_WAIT;
            end
          end
        end
        MAU_WAIT: begin
          if (mem_rvalid) begin
            r_state    <= MAU_DONE;
            resp_valid <= 1'b1;
            resp_rdata <= w_ld_data;
            resp_exc   <= '0;
          end
        end
        MAU_DONE: begin
          resp_valid <= 1'b0;
          r_state    <= MAU_IDLE;
        end
        default: r_state <= MAU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table driven through a
// responsive memory model, responses checked by a scoreboard monitor.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  typedef struct {
    logic [MEMOP_SIZE-1:0] op;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    int unsigned           gdly;
    int unsigned           rdly;
    bit                    access;
    logic [31:0]           eaddr;
    logic [3:0]            ebe;
    logic [31:0]           ewdata;
    logic [31:0]           erdata;
    logic [4:0]            eexc;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  exc;
    int unsigned cyc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic [MEMOP_SIZE-1:0] req_op;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic [4:0]            resp_exc;
  logic                  mem_req;
  logic                  mem_gnt;
  logic [31:0]           mem_addr;
  logic [3:0]            mem_byteen;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_rvalid;

  int unsigned cycle = 0;
  int          n_checks = 0;
  int          n_err = 0;
  exp_t        sb[$];
  vec_t        vecs[$];

  mem_access_unit #(.ADDR_W(32), .EXC_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_exc   (resp_exc),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_exc", 32'(resp_exc), 32'(e.exc));
        chk("resp_cycle", cycle, e.cyc);
      end
    end
  end

  task automatic run(input vec_t v);
    int unsigned c0, n_req, rcnt, lat;
    int          phase;
    bit          st;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    st  = v.op inside {MEMOP_SW, MEMOP_SH, MEMOP_SB};
    lat = !v.access ? 1 : (st ? 2 + v.gdly : 3 + v.gdly + v.rdly);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    c0 = cycle;
    req_valid = 1'b1;
    req_op    = v.op;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    sb.push_back('{v.erdata, v.eexc, c0 + lat});
    @(negedge clk); #1;
    req_valid = 1'b0;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    n_req = 0; rcnt = 0; phase = 0;
    a0 = '0; w0 = '0; b0 = '0;
    for (int k = 0; k < 40; k++) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h5A5A5A5A;
      if (sb.size() == 0 && mem_req !== 1'b1) break;
      if (mem_req === 1'b1) begin
        if (n_req == 0) begin
          chk("mem_addr", mem_addr, v.eaddr);
          chk("mem_byteen", 32'(mem_byteen), 32'(v.ebe));
          if (st) chk("mem_wdata", mem_wdata, v.ewdata);
          a0 = mem_addr; b0 = mem_byteen; w0 = mem_wdata;
        end else begin
          chk("mem_addr_stable", mem_addr, a0);
          chk("mem_byteen_stable", 32'(mem_byteen), 32'(b0));
          chk("mem_wdata_stable", mem_wdata, w0);
        end
        n_req++;
        if (phase == 0 && n_req == v.gdly + 1) begin
          mem_gnt = 1'b1;
          phase   = st ? 2 : 1;
        end
      end else if (phase == 1) begin
        if (rcnt == v.rdly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.rdata;
          phase      = 2;
        end
        rcnt++;
      end
      @(negedge clk); #1;
    end
    chk("resp_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    chk("mem_req_cycles", n_req, v.access ? v.gdly + 1 : 0);
    @(negedge clk); #1;
    chk("resp_pulse_one_cycle", 32'(resp_valid), 32'd0);
    chk("resp_rdata_hold", resp_rdata, v.erdata);
    chk("resp_exc_hold", 32'(resp_exc), 32'(v.eexc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // op, addr, wdata, rdata, gdly, rdly, access, eaddr, ebe, ewdata, erdata, eexc
    vecs.push_back('{MEMOP_SB,  32'h1003, 32'h123456AB, 32'h0,        0, 0, 1'b1, 32'h1000, 4'b1000, 32'hABABABAB, 32'h0,        5'd0});
    vecs.push_back('{MEMOP_LB,  32'h2002, 32'h0,        32'h0080FF00, 0, 0, 1'b1, 32'h2000, 4'b0000, 32'h0,        32'hFFFFFF80, 5'd0});
    vecs.push_back('{MEMOP_LBU, 32'h2002, 32'h0,        32'h0080FF00, 0, 0, 1'b1, 32'h2000, 4'b0000, 32'h0,        32'h00000080, 5'd0});
    vecs.push_back('{MEMOP_LH,  32'h3002, 32'h0,        32'h80011234, 3, 0, 1'b1, 32'h3000, 4'b0000, 32'h0,        32'hFFFF8001, 5'd0});
    vecs.push_back('{MEMOP_SH,  32'h4002, 32'hDEADBEEF, 32'h0,        0, 0, 1'b1, 32'h4000, 4'b1100, 32'hBEEFBEEF, 32'h0,        5'd0});
    vecs.push_back('{MEMOP_SW,  32'h5000, 32'hCAFEF00D, 32'h0,        2, 0, 1'b1, 32'h5000, 4'b1111, 32'hCAFEF00D, 32'h0,        5'd0});
    vecs.push_back('{MEMOP_SB,  32'h6000, 32'h0000005C, 32'h0,        0, 0, 1'b1, 32'h6000, 4'b0001, 32'h5C5C5C5C, 32'h0,        5'd0});
    vecs.push_back('{MEMOP_SB,  32'h6001, 32'h77777712, 32'h0,        1, 0, 1'b1, 32'h6000, 4'b0010, 32'h12121212, 32'h0,        5'd0});
    vecs.push_back('{MEMOP_LHU, 32'h7000, 32'h0,        32'h1234F00F, 1, 2, 1'b1, 32'h7000, 4'b0000, 32'h0,        32'h0000F00F, 5'd0});
    vecs.push_back('{MEMOP_LH,  32'h7000, 32'h0,        32'h1234700F, 0, 1, 1'b1, 32'h7000, 4'b0000, 32'h0,        32'h0000700F, 5'd0});
    vecs.push_back('{MEMOP_LW,  32'h8000, 32'h0,        32'h89ABCDEF, 0, 1, 1'b1, 32'h8000, 4'b0000, 32'h0,        32'h89ABCDEF, 5'd0});
    vecs.push_back('{MEMOP_LB,  32'h9001, 32'h0,        32'hFFFF7FFF, 0, 0, 1'b1, 32'h9000, 4'b0000, 32'h0,        32'h0000007F, 5'd0});
    vecs.push_back('{MEMOP_LBU, 32'h9000, 32'h0,        32'h000000FE, 2, 3, 1'b1, 32'h9000, 4'b0000, 32'h0,        32'h000000FE, 5'd0});
    vecs.push_back('{4'd0,      32'h0100, 32'hFFFFFFFF, 32'h0,        0, 0, 1'b0, 32'h0,    4'b0000, 32'h0,        32'h0,        5'd0});
    vecs.push_back('{MEMOP_LW,  32'h8000, 32'h0,        32'h13572468, 0, 0, 1'b1, 32'h8000, 4'b0000, 32'h0,        32'h13572468, 5'd0});
`ifdef MAU_MISALIGN_EXC_EN
    vecs.push_back('{MEMOP_LW,  32'hA001, 32'h0,        32'h11223344, 0, 0, 1'b0, 32'h0,    4'b0000, 32'h0,        32'h0,        5'd4});
    vecs.push_back('{MEMOP_SH,  32'hB001, 32'h0000ABCD, 32'h0,        0, 0, 1'b0, 32'h0,    4'b0000, 32'h0,        32'h0,        5'd5});
    vecs.push_back('{MEMOP_LHU, 32'hC003, 32'h0,        32'hBEEF0000, 0, 0, 1'b0, 32'h0,    4'b0000, 32'h0,        32'h0,        5'd4});
    vecs.push_back('{MEMOP_SW,  32'hD002, 32'h01020304, 32'h0,        0, 0, 1'b0, 32'h0,    4'b0000, 32'h0,        32'h0,        5'd5});
`else
    vecs.push_back('{MEMOP_LW,  32'hA001, 32'h0,        32'h11223344, 0, 0, 1'b1, 32'hA000, 4'b0000, 32'h0,        32'h11223344, 5'd0});
    vecs.push_back('{MEMOP_SH,  32'hB001, 32'h0000ABCD, 32'h0,        0, 0, 1'b1, 32'hB000, 4'b0011, 32'hABCDABCD, 32'h0,        5'd0});
    vecs.push_back('{MEMOP_LHU, 32'hC003, 32'h0,        32'hBEEF0000, 0, 0, 1'b1, 32'hC000, 4'b0000, 32'h0,        32'h0000BEEF, 5'd0});
    vecs.push_back('{MEMOP_SW,  32'hD002, 32'h01020304, 32'h0,        0, 0, 1'b1, 32'hD000, 4'b1111, 32'h01020304, 32'h0,        5'd0});
`endif
    vecs.push_back('{4'd15,     32'h0200, 32'h0,        32'h0,        0, 0, 1'b0, 32'h0,    4'b0000, 32'h0,        32'h0,        5'd0});

    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_byteen", 32'(mem_byteen), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_exc", 32'(resp_exc), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run(vecs[i]);

    // Reset while a load waits for rvalid: the late rvalid must be dropped.
    chk("rstw_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = MEMOP_LW; req_addr = 32'h0100;
    @(negedge clk); #1;
    req_valid = 1'b0;
    chk("rstw_mem_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk); #1;
    mem_gnt = 1'b0;
    chk("rstw_in_wait_busy", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    chk("rstw_mem_req_dropped", 32'(mem_req), 32'd0);
    chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw_ready_after", 32'(req_ready), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk); #1;
    mem_rvalid = 1'b0;
    chk("rstw_late_rvalid_resp", 32'(resp_valid), 32'd0);
    chk("rstw_late_rvalid_rdata", resp_rdata, 32'd0);
    chk("rstw_still_idle", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    chk("rstw_quiet", 32'(resp_valid | mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
